// File: rtl/bcd_to_bin_7.sv
// Two-digit BCD (00..99) to 7-bit binary converter using reverse double-dabble,
// one shift/correct iteration per clock, seven iterations per conversion.
module bcd_to_bin_7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] digit_1,
    input  logic [3:0] digit_2,
    output logic [6:0] bin,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q;
    logic [14:0] work_q;
    logic [14:0] work_d;
    logic [14:0] shifted;
    logic [2:0]  cnt_q;
    logic [6:0]  bin_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic        digits_ok;

    assign digits_ok = (digit_1 <= 4'd9) && (digit_2 <= 4'd9);

    // Work register layout: [14:11] tens nibble, [10:7] ones nibble, [6:0] binary result.
    always_comb begin
        shifted = work_q >> 1;
        work_d  = shifted;
        if (shifted[14:11] >= 4'd8) begin
            work_d[14:11] = shifted[14:11] - 4'd3;
        end
        if (shifted[10:7] >= 4'd8) begin
            work_d[10:7] = shifted[10:7] - 4'd3;
        end
    end

    // bin/err only change on entry to DONE, so they hold across the whole SHIFT phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (digits_ok) begin
                            work_q  <= {digit_1, digit_2, 7'b0};
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= SHIFT;
                        end else begin
                            bin_q   <= '0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd6) begin
                        bin_q   <= work_d[6:0];
                        err_q   <= 1'b0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bin       = bin_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_to_bin_7.sv
// Bench for bcd_to_bin_7: directed corner cases plus randomized conversions
// checked against an arithmetic reference (tens*10 + ones, err on digit > 9).
module tb_bcd_to_bin_7;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] digit_1;
  logic [3:0] digit_2;
  logic [6:0] bin;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] dbg_state;

  int n_vec;
  int n_err;

  // Scoreboard entries are {err, bin}.
  logic [7:0] exp_q[$];
  logic [6:0] hold_bin;
  logic       hold_err;

  bcd_to_bin_7 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .digit_1   (digit_1),
    .digit_2   (digit_2),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_model(input logic [3:0] d1, input logic [3:0] d2);
    int v;
    if (d1 > 9 || d2 > 9) return {1'b1, 7'd0};
    v = int'(d1) * 10 + int'(d2);
    return {1'b0, v[6:0]};
  endfunction

  // mode 0: inputs quiet; 1: digits -> 1,8 and start re-pulsed mid-conversion; 2: random noise
  task automatic run_conv(input logic [3:0] d1, input logic [3:0] d2, input int mode);
    logic [7:0] exp;
    int lat;
    int nbusy;
    bit got;
    bit valid;
    @(negedge clk);
    digit_1 = d1;
    digit_2 = d2;
    start   = 1'b1;
    valid   = (d1 <= 9) && (d2 <= 9);
    exp_q.push_back(ref_model(d1, d2));
    lat = 0;
    nbusy = 0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (busy) begin
        nbusy++;
        check("hold_bin", bin, hold_bin);
        check("hold_err", err, hold_err);
      end
      if (done) begin
        got = 1'b1;
        lat = k;
        start = 1'b0;
      end else if (mode == 1) begin
        digit_1 = 4'd1;
        digit_2 = 4'd8;
        start   = (k == 3);
      end else if (mode == 2) begin
        digit_1 = 4'($urandom_range(0, 15));
        digit_2 = 4'($urandom_range(0, 15));
        start   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    exp = exp_q.pop_front();
    if (!got) begin
      check("done_timeout", 0, 1);
    end else begin
      check("bin", bin, exp[6:0]);
      check("err", err, exp[7]);
      check("latency", lat, valid ? 8 : 1);
      check("busy_cycles", nbusy, valid ? 7 : 0);
      hold_bin = exp[6:0];
      hold_err = exp[7];
      @(negedge clk);
      check("done_one_cycle", done, 0);
      check("busy_after", busy, 0);
      check("bin_held", bin, hold_bin);
    end
  endtask

  task automatic reset_mid_shift();
    @(negedge clk);
    digit_1 = 4'd7;
    digit_2 = 4'd3;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_before_rst", busy, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_bin", bin, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    hold_bin = 7'd0;
    hold_err = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("post_rst_no_done", done, 0);
      check("post_rst_busy", busy, 0);
    end
  endtask

  task automatic back_to_back();
    int ndone;
    int last;
    @(negedge clk);
    digit_1 = 4'd6;
    digit_2 = 4'd4;
    start   = 1'b1;
    ndone = 0;
    last  = 0;
    for (int k = 1; k <= 40 && ndone < 3; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("b2b_bin", bin, 64);
        check("b2b_err", err, 0);
        check("b2b_spacing", k - last, (ndone == 1) ? 8 : 9);
        last = k;
        if (ndone == 3) start = 1'b0;
      end
    end
    check("b2b_count", ndone, 3);
    start = 1'b0;
    hold_bin = 7'd64;
    hold_err = 1'b0;
    @(negedge clk);
    check("b2b_done_end", done, 0);
    repeat (3) begin
      @(negedge clk);
      check("b2b_idle", busy, 0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    hold_bin = 7'd0;
    hold_err = 1'b0;
    rst_n   = 1'b0;
    start   = 1'b0;
    digit_1 = 4'd0;
    digit_2 = 4'd0;
    #1;
    check("reset_bin", bin, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    run_conv(4'd7, 4'd3, 0);
    run_conv(4'd9, 4'd9, 0);
    run_conv(4'd0, 4'd0, 0);
    run_conv(4'd1, 4'd5, 0);
    run_conv(4'hA, 4'd2, 0);
    run_conv(4'd1, 4'd5, 0);
    run_conv(4'd2, 4'hF, 0);
    run_conv(4'd7, 4'd3, 1);
    reset_mid_shift();
    run_conv(4'd4, 4'd2, 0);
    back_to_back();

    for (int i = 0; i < 40; i++) begin
      run_conv(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
